// File: rtl/tinyalu_pkg.sv
// Shared TinyALU definitions used by the command driver and the result collector.
package tinyalu_pkg;

  localparam int unsigned REC_W   = 24;
  localparam int unsigned RES_LSB = 0;
  localparam int unsigned OP_LSB  = 16;
  localparam int unsigned SEQ_LSB = 19;

  typedef enum logic [2:0] {
    no_op  = 3'd0,
    add_op = 3'd1,
    and_op = 3'd2,
    xor_op = 3'd3,
    mul_op = 3'd4
  } operation_t;

  function automatic logic [REC_W-1:0] make_rec(input logic [4:0]  seq,
                                                input logic [2:0]  op,
                                                input logic [15:0] result);
    logic [REC_W-1:0] rec;
    rec                    = '0;
    rec[RES_LSB +: 16]     = result;
    rec[OP_LSB  +: 3]      = op;
    rec[SEQ_LSB +: 5]      = seq;
    return rec;
  endfunction

endpackage

// File: rtl/tinyalu_result_collector.sv
// Captures TinyALU results into 24-bit records and packs them LSB-first into
// a wide package handed to the host over a valid/ack handshake.
module tinyalu_result_collector
  import tinyalu_pkg::*;
#(
  parameter int unsigned NUM           = 100,
  parameter int unsigned REC_W         = 24,
  parameter int unsigned PACKAGE_WIDTH = 2400,
  parameter int unsigned CNT_W         = $clog2(NUM + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     done,
  input  logic [2:0]               op,
  input  logic [15:0]              result,
  input  logic                     flush_req,
  input  logic                     pkt_ack,
  output logic                     pkt_valid,
  output logic [PACKAGE_WIDTH-1:0] pkt_data,
  output logic [CNT_W-1:0]         pkt_count,
  output logic [7:0]               drop_cnt
);

  if (PACKAGE_WIDTH != NUM * REC_W) begin : g_width_check
    $error("PACKAGE_WIDTH must equal NUM*REC_W");
  end
  if (REC_W != tinyalu_pkg::REC_W || NUM < 2) begin : g_param_check
    $error("REC_W must be 24 and NUM must be at least 2");
  end

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [PACKAGE_WIDTH-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]         wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0]         pkt_count_q, pkt_count_d;
  logic [4:0]               seq_q, seq_d;
  logic [7:0]               drop_cnt_q, drop_cnt_d;
  logic                     pkt_valid_q, pkt_valid_d;

  logic                     capture;
  logic [REC_W-1:0]         rec;
  logic [CNT_W-1:0]         idx_post;

  assign capture = en && done;
  assign rec     = make_rec(seq_q, op, result);

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    wr_idx_d    = wr_idx_q;
    pkt_count_d = pkt_count_q;
    seq_d       = seq_q;
    drop_cnt_d  = drop_cnt_q;
    pkt_valid_d = pkt_valid_q;
    idx_post    = wr_idx_q;

    unique case (state_q)
      COLLECT: begin
        if (capture) begin
          for (int unsigned i = 0; i < NUM; i++) begin
            if (wr_idx_q == CNT_W'(i)) buf_d[i*REC_W +: REC_W] = rec;
          end
          seq_d    = seq_q + 5'd1;
          idx_post = wr_idx_q + CNT_W'(1);
        end
        wr_idx_d = idx_post;
        // A filling capture wins over a same-cycle flush; both yield a full package.
        if (capture && wr_idx_q == CNT_W'(NUM - 1)) begin
          state_d     = HOLD;
          pkt_valid_d = 1'b1;
          pkt_count_d = CNT_W'(NUM);
        end else if (flush_req && idx_post != '0) begin
          state_d     = HOLD;
          pkt_valid_d = 1'b1;
          pkt_count_d = idx_post;
        end
      end
      HOLD: begin
        if (pkt_ack) begin
          state_d     = COLLECT;
          pkt_valid_d = 1'b0;
          pkt_count_d = '0;
          buf_d       = '0;
          wr_idx_d    = '0;
          if (capture) begin
            buf_d[0 +: REC_W] = rec;
            seq_d             = seq_q + 5'd1;
            wr_idx_d          = CNT_W'(1);
          end
        end else if (capture && drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= COLLECT;
      buf_q       <= '0;
      wr_idx_q    <= '0;
      pkt_count_q <= '0;
      seq_q       <= '0;
      drop_cnt_q  <= '0;
      pkt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      wr_idx_q    <= wr_idx_d;
      pkt_count_q <= pkt_count_d;
      seq_q       <= seq_d;
      drop_cnt_q  <= drop_cnt_d;
      pkt_valid_q <= pkt_valid_d;
    end
  end

  assign pkt_valid = pkt_valid_q;
  assign pkt_data  = buf_q;
  assign pkt_count = pkt_count_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_tinyalu_result_collector.sv
// Directed bench for tinyalu_result_collector with NUM=4 (96-bit package).
module tb_tinyalu_result_collector;

  localparam int unsigned NUM   = 4;
  localparam int unsigned PW    = 96;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             en;
  logic             done;
  logic [2:0]       op;
  logic [15:0]      result;
  logic             flush_req;
  logic             pkt_ack;
  logic             pkt_valid;
  logic [PW-1:0]    pkt_data;
  logic [CNT_W-1:0] pkt_count;
  logic [7:0]       drop_cnt;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  tinyalu_result_collector #(
    .NUM(NUM), .REC_W(24), .PACKAGE_WIDTH(PW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .done(done), .op(op),
    .result(result), .flush_req(flush_req), .pkt_ack(pkt_ack),
    .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_count(pkt_count),
    .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the edge.
  task automatic cyc(input logic d, input logic [2:0] o, input logic [15:0] r,
                     input logic fl, input logic ak);
    done = d; op = o; result = r; flush_req = fl; pkt_ack = ak;
    @(posedge clk);
    #1;
    done = 1'b0; op = '0; result = '0; flush_req = 1'b0; pkt_ack = 1'b0;
  endtask

  function automatic logic [23:0] rec(input int unsigned s, input int unsigned o,
                                      input int unsigned r);
    return {5'(s), 3'(o), 16'(r)};
  endfunction

  initial begin
    logic [PW-1:0] held;
    reset_n = 1'b0; en = 1'b1; done = 1'b0; op = '0; result = '0;
    flush_req = 1'b0; pkt_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", pkt_valid, 0);
    chk("rst_data",  pkt_data,  0);
    chk("rst_count", pkt_count, 0);
    chk("rst_drop",  drop_cnt,  0);
    reset_n = 1'b1;

    // Full package
    cyc(1, 3'd1, 16'h0003, 0, 0);
    cyc(1, 3'd1, 16'h0010, 0, 0);
    cyc(1, 3'd3, 16'h00FF, 0, 0);
    chk("full_not_yet", pkt_valid, 0);
    cyc(1, 3'd4, 16'hFE01, 0, 0);
    chk("full_valid", pkt_valid, 1);
    chk("full_count", pkt_count, 4);
    chk("full_rec0",  pkt_data[23:0],  24'h010003);
    chk("full_rec3",  pkt_data[95:72], 24'h1CFE01);
    chk("full_data",  pkt_data, {24'h1CFE01, 24'h1300FF, 24'h090010, 24'h010003});
    held = pkt_data;

    // Drops while holding, flush ignored in HOLD
    cyc(1, 3'd2, 16'hAAAA, 0, 0);
    cyc(1, 3'd2, 16'hAAAA, 1, 0);
    cyc(1, 3'd2, 16'hAAAA, 0, 0);
    chk("drop_cnt",   drop_cnt, 3);
    chk("drop_data",  pkt_data, held);
    chk("drop_count", pkt_count, 4);
    chk("drop_valid", pkt_valid, 1);

    cyc(0, 3'd0, 16'h0000, 0, 1);
    chk("ack_valid", pkt_valid, 0);
    chk("ack_data",  pkt_data, 0);
    cyc(0, 3'd0, 16'h0000, 0, 1);
    chk("ack_collect_ignored", pkt_valid, 0);

    // Partial flush; seq resumes at 4 after the drops
    cyc(1, 3'd2, 16'h1234, 0, 0);
    cyc(1, 3'd3, 16'h5678, 0, 0);
    cyc(0, 3'd0, 16'h0000, 1, 0);
    chk("part_valid", pkt_valid, 1);
    chk("part_count", pkt_count, 2);
    chk("part_data",  pkt_data, {48'h0, 24'h2B5678, 24'h221234});
    cyc(0, 3'd0, 16'h0000, 0, 0);
    cyc(0, 3'd0, 16'h0000, 0, 0);
    chk("part_held", pkt_valid, 1);

    // Ack + capture same cycle, then capture + flush same cycle
    cyc(1, 3'd4, 16'h0102, 0, 1);
    chk("ackcap_valid", pkt_valid, 0);
    chk("ackcap_data",  pkt_data, {72'h0, 24'h340102});
    cyc(1, 3'd1, 16'h0007, 1, 0);
    chk("capflush_valid", pkt_valid, 1);
    chk("capflush_count", pkt_count, 2);
    chk("capflush_data",  pkt_data, {48'h0, 24'h390007, 24'h340102});
    cyc(0, 3'd0, 16'h0000, 0, 1);

    // Filling capture and flush in the same cycle: seq 8..11
    cyc(1, 3'd1, 16'h0001, 0, 0);
    cyc(1, 3'd1, 16'h0002, 0, 0);
    cyc(1, 3'd1, 16'h0003, 0, 0);
    cyc(1, 3'd1, 16'h0004, 1, 0);
    chk("fullflush_count", pkt_count, 4);
    chk("fullflush_rec3",  pkt_data[95:72], rec(11, 1, 4));
    cyc(0, 3'd0, 16'h0000, 0, 1);

    // en low: nothing recorded, nothing dropped, empty flush ignored
    en = 1'b0;
    cyc(1, 3'd2, 16'hDEAD, 0, 0);
    cyc(1, 3'd2, 16'hDEAD, 0, 0);
    cyc(0, 3'd0, 16'h0000, 1, 0);
    chk("enlow_valid", pkt_valid, 0);
    chk("enlow_data",  pkt_data, 0);
    chk("enlow_drop",  drop_cnt, 3);
    en = 1'b1;

    // Five full packages take seq 12..31
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 4; k++) cyc(1, 3'(k), 16'(100 + 4*p + k), 0, 0);
      chk("wrap_pkg", pkt_data, {rec(15+4*p, 3, 103+4*p), rec(14+4*p, 2, 102+4*p),
                                 rec(13+4*p, 1, 101+4*p), rec(12+4*p, 0, 100+4*p)});
      cyc(0, 3'd0, 16'h0000, 0, 1);
    end
    // 33rd accepted record wraps seq to 0
    cyc(1, 3'd1, 16'hBEEF, 0, 0);
    cyc(1, 3'd0, 16'h0001, 0, 0);
    chk("wrap_seq0", pkt_data[47:0], {24'h080001, 24'h01BEEF});

    // Reset mid-package
    reset_n = 1'b0;
    cyc(0, 3'd0, 16'h0000, 0, 0);
    reset_n = 1'b1;
    chk("mid_rst_valid", pkt_valid, 0);
    chk("mid_rst_data",  pkt_data, 0);
    chk("mid_rst_count", pkt_count, 0);
    chk("mid_rst_drop",  drop_cnt, 0);
    cyc(1, 3'd2, 16'h4321, 1, 0);
    chk("post_rst_count", pkt_count, 1);
    chk("post_rst_data",  pkt_data, {72'h0, 24'h024321});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
